param_shift_reg: RTL and testbench



---
 rtl/param_shift_reg.sv | 168 ++++++++++++++++
 tb/tb_param_shift_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/param_shift_reg.sv
// WIDTH-bit holding register with true/complement outputs and a multi-cycle
// shift/rotate engine that moves one bit position per clock.
module param_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               AMTW      = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMTW-1:0]  amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             sin,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_SHR   = 3'b011;
   localparam logic [2:0] OP_ROL   = 3'b100;
   localparam logic [2:0] OP_ROR   = 3'b101;
   localparam logic [2:0] OP_ASR   = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

   localparam logic [AMTW-1:0] WIDTH_A = AMTW'(WIDTH);
   localparam logic [AMTW-1:0] ONE_A   = AMTW'(1);
   localparam logic [AMTW-1:0] ZERO_A  = {AMTW{1'b0}};

   typedef enum logic {
      S_IDLE = 1'b0,
      S_STEP = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [AMTW-1:0]  rem_q, rem_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [AMTW-1:0]  amt_sat_s;
   logic [WIDTH:0]   step_new_s;
   logic [WIDTH:0]   step_cur_s;

   // One bit-position move; result is {bit shifted out, next register value}.
   function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] q_v,
                                              input logic [2:0]       op_v,
                                              input logic             sin_v);
      logic [WIDTH:0] res;
      case (op_v)
         OP_SHL:  res = {q_v[WIDTH-1], q_v[WIDTH-2:0], sin_v};
         OP_SHR:  res = {q_v[0], sin_v, q_v[WIDTH-1:1]};
         OP_ROL:  res = {q_v[WIDTH-1], q_v[WIDTH-2:0], q_v[WIDTH-1]};
         OP_ROR:  res = {q_v[0], q_v[0], q_v[WIDTH-1:1]};
         OP_ASR:  res = {q_v[0], q_v[WIDTH-1], q_v[WIDTH-1:1]};
         default: res = {1'b0, q_v};
      endcase
      return res;
   endfunction

   // Amount saturation and candidate step results for new and latched ops.
   always_comb begin
      amt_sat_s  = (amt > WIDTH_A) ? WIDTH_A : amt;
      step_new_s = step_fn(q_q, op, sin);
      step_cur_s = step_fn(q_q, op_q, sin);
   end

   // Next-state logic: command decode in IDLE, stepping in STEP.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      op_d    = op_q;
      q_d     = q_q;
      sout_d  = sout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               case (op)
                  OP_HOLD: begin
                     done_d = 1'b1;
                  end
                  OP_LOAD: begin
                     q_d    = load_data;
                     done_d = 1'b1;
                  end
                  OP_CLEAR: begin
                     q_d    = {WIDTH{1'b0}};
                     done_d = 1'b1;
                  end
                  default: begin
                     if (amt_sat_s == ZERO_A) begin
                        done_d = 1'b1;
                     end else begin
                        q_d    = step_new_s[WIDTH-1:0];
                        sout_d = step_new_s[WIDTH];
                        op_d   = op;
                        if (amt_sat_s == ONE_A) begin
                           done_d = 1'b1;
                        end else begin
                           state_d = S_STEP;
                           rem_d   = amt_sat_s - ONE_A;
                           busy_d  = 1'b1;
                        end
                     end
                  end
               endcase
            end else begin
               done_d = 1'b0;
            end
         end
         S_STEP: begin
            // start is deliberately not looked at here: no queuing while busy.
            q_d    = step_cur_s[WIDTH-1:0];
            sout_d = step_cur_s[WIDTH];
            rem_d  = rem_q - ONE_A;
            if (rem_q == ONE_A) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= ZERO_A;
         op_q    <= OP_HOLD;
         q_q     <= RESET_VAL;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         q_q     <= q_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Q    = q_q;
   assign Qbar = ~q_q;
   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg: command table with a scoreboard
// queue, plus hand-written sequences for per-step, reset and back-to-back cases.
module tb_param_shift_reg;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic [3:0] amt;
   logic [7:0] load_data;
   logic       sin;
   logic [7:0] Q;
   logic [7:0] Qbar;
   logic       sout;
   logic       busy;
   logic       done;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] op;
      logic [3:0] amt;
      logic [7:0] ld;
      logic       sin;
      int         inject;
      logic [7:0] exp_q;
      logic       exp_sout;
      int         exp_steps;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic       sout;
      int         steps;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[12];

   param_shift_reg dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt),
      .load_data(load_data), .sin(sin), .Q(Q), .Qbar(Qbar),
      .sout(sout), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic run(input vec_t v);
      exp_t e;
      exp_t got;
      int   steps;
      int   busyc;
      sin = v.sin;
      @(negedge clk);
      start = 1'b1; op = v.op; amt = v.amt; load_data = v.ld;
      e.q = v.exp_q; e.sout = v.exp_sout; e.steps = v.exp_steps;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; op = 3'b001; amt = 4'd1; load_data = 8'h33;
      steps = 1; busyc = 0;
      while (!done && steps < 40) begin
         if (busy) busyc++;
         if (steps == v.inject) begin
            start = 1'b1; op = 3'b001; load_data = 8'h55;
         end
         @(posedge clk); #1;
         start = 1'b0;
         steps++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk("q", {24'd0, Q}, {24'd0, got.q});
         chk("qbar", {24'd0, Qbar}, {24'd0, ~got.q});
         chk("sout", {31'd0, sout}, {31'd0, got.sout});
         chk("steps", steps, got.steps);
         chk("busy_cycles", busyc, got.steps - 1);
         chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
      @(posedge clk); #1;
      chk("done_drop", {31'd0, done}, 32'd0);
   endtask

   function automatic vec_t mk(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                               input logic s, input int inj, input logic [7:0] eq,
                               input logic es, input int st);
      vec_t v;
      v.op = o; v.amt = a; v.ld = d; v.sin = s; v.inject = inj;
      v.exp_q = eq; v.exp_sout = es; v.exp_steps = st;
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(3'b001, 4'd0,  8'hA5, 1'b0, -1, 8'hA5, 1'b0, 1);
      tbl[1]  = mk(3'b001, 4'd0,  8'hA5, 1'b0, -1, 8'hA5, 1'b1, 1);
      tbl[2]  = mk(3'b101, 4'd4,  8'h00, 1'b0, -1, 8'h5A, 1'b0, 4);
      tbl[3]  = mk(3'b001, 4'd0,  8'h80, 1'b0, -1, 8'h80, 1'b0, 1);
      tbl[4]  = mk(3'b110, 4'd2,  8'h00, 1'b0, -1, 8'hE0, 1'b0, 2);
      tbl[5]  = mk(3'b100, 4'd3,  8'h00, 1'b0, -1, 8'h07, 1'b1, 3);
      tbl[6]  = mk(3'b010, 4'd8,  8'h00, 1'b0, -1, 8'h00, 1'b1, 8);
      tbl[7]  = mk(3'b001, 4'd0,  8'hFF, 1'b0, -1, 8'hFF, 1'b1, 1);
      tbl[8]  = mk(3'b011, 4'd12, 8'h00, 1'b0,  3, 8'h00, 1'b1, 8);
      tbl[9]  = mk(3'b001, 4'd0,  8'hC3, 1'b0, -1, 8'hC3, 1'b1, 1);
      tbl[10] = mk(3'b100, 4'd8,  8'h00, 1'b0, -1, 8'hC3, 1'b1, 8);
      tbl[11] = mk(3'b010, 4'd8,  8'h00, 1'b1, -1, 8'hFF, 1'b1, 8);

      rst_n = 1'b0; start = 1'b0; op = 3'b000; amt = 4'd0;
      load_data = 8'h00; sin = 1'b0;
      #2;
      chk("rst_q", {24'd0, Q}, 32'h00);
      chk("rst_qbar", {24'd0, Qbar}, 32'hFF);
      chk("rst_sout", {31'd0, sout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      run(tbl[0]);

      // SHL by 3 with sin=1, checked after every step edge.
      sin = 1'b1;
      @(negedge clk);
      start = 1'b1; op = 3'b010; amt = 4'd3;
      @(posedge clk); #1; start = 1'b0;
      chk("shl1_q", {24'd0, Q}, 32'h4B);
      chk("shl1_sout", {31'd0, sout}, 32'd1);
      chk("shl1_busy", {31'd0, busy}, 32'd1);
      chk("shl1_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk("shl2_q", {24'd0, Q}, 32'h97);
      chk("shl2_sout", {31'd0, sout}, 32'd0);
      chk("shl2_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("shl3_q", {24'd0, Q}, 32'h2F);
      chk("shl3_sout", {31'd0, sout}, 32'd1);
      chk("shl3_busy", {31'd0, busy}, 32'd0);
      chk("shl3_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("shl_done_drop", {31'd0, done}, 32'd0);

      for (int i = 1; i < 12; i++) run(tbl[i]);

      // Asynchronous reset between edges in the middle of a SHL.
      run(mk(3'b001, 4'd0, 8'hA5, 1'b0, -1, 8'hA5, 1'b1, 1));
      @(negedge clk);
      start = 1'b1; op = 3'b010; amt = 4'd5; sin = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_q", {24'd0, Q}, 32'h00);
      chk("arst_qbar", {24'd0, Qbar}, 32'hFF);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_sout", {31'd0, sout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(mk(3'b111, 4'd0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1));
      run(mk(3'b000, 4'd0, 8'h00, 1'b0, -1, 8'h00, 1'b0, 1));

      // amt=0 completes immediately; a LOAD on the done cycle is accepted.
      run(mk(3'b001, 4'd0, 8'h81, 1'b0, -1, 8'h81, 1'b0, 1));
      @(negedge clk);
      start = 1'b1; op = 3'b010; amt = 4'd0; sin = 1'b1;
      @(posedge clk); #1;
      chk("amt0_done", {31'd0, done}, 32'd1);
      chk("amt0_q", {24'd0, Q}, 32'h81);
      chk("amt0_busy", {31'd0, busy}, 32'd0);
      chk("amt0_sout", {31'd0, sout}, 32'd0);
      op = 3'b001; load_data = 8'h3C;
      @(posedge clk); #1; start = 1'b0;
      chk("b2b_q", {24'd0, Q}, 32'h3C);
      chk("b2b_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("b2b_done_drop", {31'd0, done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
